// File: rtl/round_robin_arbiter_n_locking_if.sv
// Request/grant bundle between N requesters and the round-robin locking arbiter.
// The arbiter connects through the slave modport; requesters drive through master.
interface round_robin_arbiter_n_locking_if #(
   parameter int N = 4
);
   localparam int IW = (N > 1) ? $clog2(N) : 1;

   logic [N-1:0]  req;
   logic [N-1:0]  last;
   logic [N-1:0]  grant;
   logic          grant_valid;
   logic [IW-1:0] grant_idx;
   logic          preempt;

   modport master (
      output req, last,
      input  grant, grant_valid, grant_idx, preempt
   );

   modport slave (
      input  req, last,
      output grant, grant_valid, grant_idx, preempt
   );
endinterface

// File: rtl/round_robin_arbiter_n_locking.sv
// N-requester round-robin arbiter that locks the grant for a multi-cycle transaction.
// Defining RR_ARB_MAX_HOLD_EN adds forced release after MAX_HOLD granted cycles.
module round_robin_arbiter_n_locking #(
   parameter int N        = 4,
   parameter int MAX_HOLD = 8
) (
   input  logic                          clk,
   input  logic                          rst,
   round_robin_arbiter_n_locking_if.slave bus
);
   localparam int IW = (N > 1) ? $clog2(N) : 1;
   localparam logic [0:0] IDLE = 1'b0;
   localparam logic [0:0] BUSY = 1'b1;

   logic [0:0]    state;
   logic [IW-1:0] ptr;
   logic [IW-1:0] owner;
   logic [IW-1:0] pick;
   logic          pick_found;
   logic [IW-1:0] sel;
   logic          take;
   logic          done;
   logic          is_preempt;
   logic [N-1:0]  grant_vec;

   // Rotating search: the requester just after the last winner has top priority.
   always_comb begin
      int            j;
      logic [IW-1:0] idx;
      j          = 0;
      idx        = '0;
      pick       = '0;
      pick_found = 1'b0;
      for (int k = 1; k <= N; k++) begin
         j   = (int'(ptr) + k) % N;
         idx = IW'(j);
         if (!pick_found && bus.req[idx]) begin
            pick       = idx;
            pick_found = 1'b1;
         end
      end
   end

   // A locked owner shuts out every other requester until it finishes or drops.
   always_comb begin
      sel  = '0;
      take = 1'b0;
      if (rst) begin
         if (state == IDLE) begin
            sel  = pick;
            take = pick_found;
         end else begin
            sel  = owner;
            take = bus.req[owner];
         end
      end
      done      = take && bus.last[sel];
      grant_vec = '0;
      if (take) begin
         grant_vec[sel] = 1'b1;
      end
   end

   assign bus.grant       = grant_vec;
   assign bus.grant_valid = take;
   assign bus.grant_idx   = take ? sel : '0;
   assign bus.preempt     = is_preempt;

`ifdef RR_ARB_MAX_HOLD_EN
   localparam int CW = $clog2(MAX_HOLD + 1);

   logic [CW-1:0] hold_cnt;
   logic [CW-1:0] cur_cnt;
   logic          others_pending;

   // cur_cnt includes the present cycle, so the opening IDLE grant already counts as one.
   always_comb begin
      if (state == IDLE) begin
         cur_cnt = CW'(1);
      end else if (hold_cnt >= CW'(MAX_HOLD)) begin
         cur_cnt = CW'(MAX_HOLD);
      end else begin
         cur_cnt = hold_cnt + CW'(1);
      end
      others_pending = (bus.req & ~grant_vec) != '0;
      is_preempt     = take && !bus.last[sel] && (cur_cnt == CW'(MAX_HOLD)) && others_pending;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         hold_cnt <= '0;
      end else if (take && !done && !is_preempt) begin
         hold_cnt <= cur_cnt;
      end else begin
         hold_cnt <= '0;
      end
   end
`else
   assign is_preempt = 1'b0;
`endif

   // ptr tracks the last winner; a release of any kind leaves it on the owner.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= IDLE;
         ptr   <= IW'(N - 1);
         owner <= '0;
      end else if (state == IDLE) begin
         if (take) begin
            ptr <= sel;
            if (!done && !is_preempt) begin
               state <= BUSY;
               owner <= sel;
            end
         end
      end else begin
         if (!take || done || is_preempt) begin
            state <= IDLE;
         end
      end
   end
endmodule

// File: tb/tb_round_robin_arbiter_n_locking.sv
// Self-checking bench: directed scenarios with literal expectations plus
// randomized traffic compared every cycle against a transaction-level model.
module tb_round_robin_arbiter_n_locking;
   localparam int N    = 4;
   localparam int MAXH = 3;
`ifdef RR_ARB_MAX_HOLD_EN
   localparam bit FEAT = 1'b1;
`else
   localparam bit FEAT = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst;
   int   errors = 0;
   int   checks = 0;

   round_robin_arbiter_n_locking_if #(.N(N)) bus ();

   round_robin_arbiter_n_locking #(.N(N), .MAX_HOLD(MAXH)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   // Model state: whether a transaction is open, who owns it, who won last, cycles used.
   bit m_busy;
   int m_ptr;
   int m_owner;
   int m_cnt;

   // Works out this cycle's winner straight from the arbitration rules.
   function automatic void modelEval(output logic [3:0] g, output int win, output bit pre,
                                     output bit ends, output int cur);
      int cand;
      g    = '0;
      win  = 0;
      pre  = 1'b0;
      ends = 1'b0;
      cur  = 0;
      cand = -1;
      if (rst !== 1'b1) return;
      if (m_busy) begin
         if (bus.req[m_owner]) cand = m_owner;
         cur = (m_cnt + 1 > MAXH) ? MAXH : m_cnt + 1;
      end else begin
         for (int k = 1; k <= N; k++) begin
            if (cand < 0 && bus.req[(m_ptr + k) % N]) cand = (m_ptr + k) % N;
         end
         cur = 1;
      end
      if (cand < 0) begin
         ends = 1'b1;
         return;
      end
      g[cand] = 1'b1;
      win     = cand;
      pre     = FEAT && (cur == MAXH) && !bus.last[cand] && ((bus.req & ~g) != 4'b0000);
      ends    = bus.last[cand] || pre;
   endfunction

   always @(posedge clk or negedge rst) begin : modelUpdate
      logic [3:0] g;
      int         win;
      int         cur;
      bit         pre;
      bit         ends;
      if (!rst) begin
         m_busy  <= 1'b0;
         m_ptr   <= N - 1;
         m_owner <= 0;
         m_cnt   <= 0;
      end else begin
         modelEval(g, win, pre, ends, cur);
         if (g != 4'b0000) begin
            m_ptr <= win;
            if (ends) begin
               m_busy <= 1'b0;
               m_cnt  <= 0;
            end else begin
               m_busy  <= 1'b1;
               m_owner <= win;
               m_cnt   <= cur;
            end
         end else begin
            m_busy <= 1'b0;
            m_cnt  <= 0;
         end
      end
   end

   // Every falling edge the DUT outputs must agree with the model and the grant invariants.
   always @(negedge clk) begin : compareProc
      logic [3:0] g;
      int         win;
      int         cur;
      bit         pre;
      bit         ends;
      modelEval(g, win, pre, ends, cur);
      checks++;
      if (bus.grant !== g || bus.grant_valid !== (g != 4'b0000) || bus.grant_idx !== 2'(win) ||
          bus.preempt !== pre || (bus.grant & ~bus.req) != 4'b0000) begin
         errors++;
         $display("[TB] FAIL model_cmp t=%0t got grant=%b valid=%b idx=%0d preempt=%b want grant=%b idx=%0d preempt=%b",
                  $time, bus.grant, bus.grant_valid, bus.grant_idx, bus.preempt, g, win, pre);
      end
   end

   task automatic applyStimulus(input logic [3:0] r, input logic [3:0] l);
      bus.req  = r;
      bus.last = l;
   endtask

   task automatic checkOutput(input string name, input logic [3:0] eg, input int ei, input bit ep);
      #3;
      checks++;
      if (bus.grant !== eg || bus.grant_valid !== (eg != 4'b0000) ||
          bus.grant_idx !== 2'(ei) || bus.preempt !== ep) begin
         errors++;
         $display("[TB] FAIL %s got grant=%b valid=%b idx=%0d preempt=%b want grant=%b idx=%0d preempt=%b",
                  name, bus.grant, bus.grant_valid, bus.grant_idx, bus.preempt, eg, ei, ep);
      end
   endtask

   task automatic nextCycle();
      @(posedge clk);
      #1;
   endtask

   task automatic doReset();
      applyStimulus(4'b0000, 4'b0000);
      rst = 1'b0;
      nextCycle();
      rst = 1'b1;
   endtask

   initial begin
      logic [3:0] flip;
      logic [3:0] lmask;
      rst = 1'b0;
      applyStimulus(4'b1111, 4'b1111);
      nextCycle();
      checkOutput("reset_hold_a", 4'b0000, 0, 1'b0);
      nextCycle();
      checkOutput("reset_hold_b", 4'b0000, 0, 1'b0);
      nextCycle();
      rst = 1'b1;
      checkOutput("rotate_0", 4'b0001, 0, 1'b0);
      nextCycle();
      checkOutput("rotate_1", 4'b0010, 1, 1'b0);
      nextCycle();
      checkOutput("rotate_2", 4'b0100, 2, 1'b0);
      nextCycle();
      checkOutput("rotate_3", 4'b1000, 3, 1'b0);
      nextCycle();
      checkOutput("rotate_wrap", 4'b0001, 0, 1'b0);
      nextCycle();

`ifndef RR_ARB_MAX_HOLD_EN
      doReset();
      applyStimulus(4'b0011, 4'b0000);
      for (int i = 0; i < 3; i++) begin
         checkOutput("lock_hold", 4'b0001, 0, 1'b0);
         nextCycle();
      end
      applyStimulus(4'b0011, 4'b0001);
      checkOutput("lock_last", 4'b0001, 0, 1'b0);
      nextCycle();
      applyStimulus(4'b0011, 4'b0000);
      checkOutput("lock_handover", 4'b0010, 1, 1'b0);
      nextCycle();
`endif

      doReset();
      applyStimulus(4'b0101, 4'b0000);
      checkOutput("abort_own_a", 4'b0001, 0, 1'b0);
      nextCycle();
      checkOutput("abort_own_b", 4'b0001, 0, 1'b0);
      nextCycle();
      applyStimulus(4'b0100, 4'b0000);
      checkOutput("abort_drop", 4'b0000, 0, 1'b0);
      nextCycle();
      checkOutput("abort_next", 4'b0100, 2, 1'b0);
      nextCycle();

      doReset();
      applyStimulus(4'b1000, 4'b1000);
      checkOutput("wrap_three", 4'b1000, 3, 1'b0);
      nextCycle();
      applyStimulus(4'b1001, 4'b1001);
      checkOutput("wrap_zero", 4'b0001, 0, 1'b0);
      nextCycle();
      checkOutput("wrap_back", 4'b1000, 3, 1'b0);
      nextCycle();

      doReset();
      applyStimulus(4'b0100, 4'b0000);
      checkOutput("midrst_idle", 4'b0100, 2, 1'b0);
      nextCycle();
      checkOutput("midrst_busy", 4'b0100, 2, 1'b0);
      rst = 1'b0;
      checkOutput("midrst_drop", 4'b0000, 0, 1'b0);
      nextCycle();
      applyStimulus(4'b1000, 4'b1000);
      nextCycle();
      rst = 1'b1;
      checkOutput("midrst_release", 4'b1000, 3, 1'b0);
      nextCycle();

`ifdef RR_ARB_MAX_HOLD_EN
      doReset();
      applyStimulus(4'b0011, 4'b0000);
      checkOutput("hold_c1", 4'b0001, 0, 1'b0);
      nextCycle();
      checkOutput("hold_c2", 4'b0001, 0, 1'b0);
      nextCycle();
      checkOutput("hold_preempt", 4'b0001, 0, 1'b1);
      nextCycle();
      checkOutput("hold_after", 4'b0010, 1, 1'b0);
      nextCycle();
      doReset();
      applyStimulus(4'b0001, 4'b0000);
      for (int i = 0; i < 5; i++) begin
         checkOutput("hold_saturate", 4'b0001, 0, 1'b0);
         nextCycle();
      end
`endif

      // Requests mostly persist so transactions span several cycles; rare async resets.
      doReset();
      for (int c = 0; c < 3000; c++) begin
         for (int b = 0; b < N; b++) begin
            flip[b]  = ($urandom_range(0, 3) == 0);
            lmask[b] = ($urandom_range(0, 3) == 0);
         end
         applyStimulus(bus.req ^ flip, lmask);
         if ($urandom_range(0, 199) == 0) begin
            #2 rst = 1'b0;
            nextCycle();
            rst = 1'b1;
         end else begin
            nextCycle();
         end
      end

      applyStimulus(4'b0000, 4'b0000);
      nextCycle();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/round_robin_arbiter_n_locking.md
Name: round_robin_arbiter_n_locking

Overview:
- Parametrised N-requester round-robin arbiter with transaction locking.
- A requester keeps the grant across a multi-cycle transaction until it signals `last` or drops its request. Priority then rotates to the next index.
- Sits in front of shared resources (bus master port, memory port) and generalises the two-requester round-robin arbiter to N channels.

Parameters:
- N, 4, number of requesters; legal range N >= 2.
- MAX_HOLD, 8, maximum granted cycles per transaction before forced release; used only with the optional feature; must be >= 1.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  reset, asynchronous, active-low (0 = reset).
- req  input  N  request per requester; held high for the whole transaction.
- last  input  N  last[i]=1 marks the final cycle of requester i's transaction; sampled only while i is granted.
- grant  output  N  one-hot grant, or all zeros.
- grant_valid  output  1  OR of grant.
- grant_idx  output  $clog2(N)  binary index of granted requester; 0 when grant_valid=0.
- preempt  output  1  high in the cycle a transaction is forcibly released; constant 0 without the optional feature.

Behaviour:
- Registered state:
  - state: IDLE or BUSY.
  - ptr: index of the last granted requester.
  - owner: index of the locked requester.
  - hold_cnt (optional feature only).
- Reset values:
  - While rst=0: state=IDLE, ptr=N-1, owner=0, hold_cnt=0.
  - grant, grant_valid, grant_idx and preempt are forced to 0 combinationally, regardless of req.
- Pick function: first i with req[i]=1, searching (ptr+1) mod N, (ptr+2) mod N, ... with wrap-around. After reset, index 0 has highest priority.
- Grant is combinational from state and req. There is zero-cycle latency from req to grant in IDLE.
- IDLE:
  - req=0: grant=0, stay IDLE.
  - Otherwise grant=onehot(pick) and ptr<=pick.
  - If last[pick]=1: stay IDLE (single-cycle transaction). Next cycle re-arbitrates from pick+1.
  - Else: state<=BUSY, owner<=pick.
- BUSY:
  - req[owner]=1: grant=onehot(owner); requests from other indices are ignored.
    - last[owner]=1: state<=IDLE.
    - Otherwise remain BUSY.
  - req[owner]=0 (abort): grant=0 this cycle, state<=IDLE. There is no new grant in the abort cycle. The next cycle picks starting from owner+1.
- Invariants:
  - At most one grant bit is set.
  - grant[i]=1 implies req[i]=1.
- Simultaneous events: last and request-drop from the owner in the same cycle is treated as abort.
- Fairness: with all N requesting single-cycle transactions, each index is granted exactly once every N cycles.
- Asynchronous reset mid-BUSY immediately drops the grant. No transaction state survives reset.
- X on req or last is not supported; the bench drives known values at all times.

Optional Feature:
- Macro: RR_ARB_MAX_HOLD_EN.
- With the macro defined:
  - hold_cnt counts granted cycles of the current transaction. The IDLE grant cycle counts as 1, and each further granted BUSY cycle adds 1.
  - When hold_cnt reaches MAX_HOLD on a granted cycle, last[owner]=0, and (req & ~onehot(owner)) != 0: grant is still given that cycle, preempt=1, state<=IDLE. The next pick starts at owner+1.
  - If no other requester is pending, the owner keeps the grant and hold_cnt saturates at MAX_HOLD.
  - hold_cnt clears on every return to IDLE.
- Without the macro: no counter is built, preempt is tied 0, and transactions are unbounded.

Test Plan (N=4, MAX_HOLD=3 where relevant):
1. Reset and rotation:
   - Stimulus: rst=0 with req=1111 → grant=0000 throughout reset. Release reset with req=1111, last=1111.
   - Required: grant sequence 0001, 0010, 0100, 1000, 0001 on consecutive cycles; grant_idx 0, 1, 2, 3, 0.
2. Lock:
   - Stimulus: req=0011. last=0000 for 3 cycles, then last=0001.
   - Required: grant=0001 for 4 cycles, then 0010 on the 5th cycle.
3. Abort:
   - Stimulus: req=0101, last=0. Requester 0 owns the grant; it drops req[0] after 2 cycles.
   - Required: grant=0000 in the drop cycle, grant=0100 the next cycle.
4. Wrap-around:
   - Stimulus: grant requester 3 with last=1000. Then req=1001, last=1001.
   - Required: grant=0001, then 1000.
5. Reset mid-transaction:
   - Stimulus: assert rst=0 asynchronously while BUSY with owner 2.
   - Required: grant=0000 before the next clock edge. After reset release with req=1000, last=1000: grant=1000, grant_idx=3.
6. RR_ARB_MAX_HOLD_EN:
   - Stimulus: req=0011, last=0000.
   - Required: grant=0001 for 3 cycles with preempt=1 on the 3rd, then grant=0010.
   - With req=0001 only: grant=0001 persists past 3 cycles with preempt=0.
